// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for a 5-stage RISC-V pipeline with a mul/div wait FSM.
// Define PIPE_PERF_EN to build the stall/flush performance counters; otherwise they read 0.
module pipe_hazard_ctrl #(
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic [4:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic        branch_taken_ex,
  input  logic        md_start,
  input  logic        md_done,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        md_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  // MD_TIMEOUT is expected to be at least 2.
  localparam int unsigned CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  typedef enum logic {
    IDLE,
    MD_WAIT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] md_cnt;
  logic [CNT_W-1:0] md_cnt_inc;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             err_set;
  logic             load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       mem_we,
    input logic [4:0] mrd,
    input logic       wb_we,
    input logic [4:0] wrd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_we && (mrd != 5'd0) && (mrd == rs)) begin
      sel = 2'b10;
    end else if (wb_we && (wrd != 5'd0) && (wrd == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
  assign fwd_b = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign md_cnt_inc = md_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The cycle that issues a mul/div already holds the pipeline, so N-cycle ops cost N stall cycles.
  always_comb begin
    state_next   = state;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (md_start) begin
          cnt_clr = 1'b1;
          if (!md_done) begin
            state_next   = MD_WAIT;
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
          end
        end else if (branch_taken_ex) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end else if (load_use) begin
          stall_pc    = 1'b1;
          stall_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
      end
      MD_WAIT: begin
        cnt_inc = 1'b1;
        if (md_done) begin
          state_next = IDLE;
        end else begin
          stall_pc     = 1'b1;
          stall_if_id  = 1'b1;
          stall_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          if (md_cnt_inc == CNT_LAST) begin
            err_set    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (cnt_clr) begin
      md_cnt <= '0;
    end else if (cnt_inc) begin
      md_cnt <= md_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_err <= 1'b0;
    end else if (err_set) begin
      md_err <= 1'b1;
    end
  end

`ifdef PIPE_PERF_EN
  logic any_flush;

  assign any_flush = flush_if_id | flush_id_ex | flush_ex_mem;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_pc && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (any_flush && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl: one default instance, one with MD_TIMEOUT=8.
// Counter expectations follow PIPE_PERF_EN when the bench is built with it.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, mem_reg_write, wb_reg_write;
  logic        branch_taken_ex, md_start, md_done;

  logic        stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_ex_mem;
  logic [1:0]  fwd_a, fwd_b;
  logic        md_err;
  logic [31:0] stall_cnt, flush_cnt;

  logic        t_stall_pc, t_stall_if_id, t_stall_id_ex, t_flush_if_id, t_flush_id_ex, t_flush_ex_mem;
  logic [1:0]  t_fwd_a, t_fwd_b;
  logic        t_md_err;
  logic [31:0] t_stall_cnt, t_flush_cnt;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken_ex(branch_taken_ex), .md_start(md_start), .md_done(md_done),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .md_err(md_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.MD_TIMEOUT(8)) u_dut_to (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken_ex(branch_taken_ex), .md_start(md_start), .md_done(md_done),
    .stall_pc(t_stall_pc), .stall_if_id(t_stall_if_id), .stall_id_ex(t_stall_id_ex),
    .flush_if_id(t_flush_if_id), .flush_id_ex(t_flush_id_ex), .flush_ex_mem(t_flush_ex_mem),
    .fwd_a(t_fwd_a), .fwd_b(t_fwd_b), .md_err(t_md_err),
    .stall_cnt(t_stall_cnt), .flush_cnt(t_flush_cnt)
  );

`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ctl = {stall_pc, stall_if_id, stall_id_ex, flush_if_id, flush_id_ex, flush_ex_mem}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b110010;
  localparam logic [5:0] C_REDIR = 6'b000110;
  localparam logic [5:0] C_MD    = 6'b111001;

  typedef struct packed {
    logic [5:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       err;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          inst_sel = 0;
  logic [31:0] exp_stall = 0;
  logic [31:0] exp_flush = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic quiet();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
    branch_taken_ex = 0; md_start = 0; md_done = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    quiet();
  endtask

  task automatic apply_stimulus(input logic [5:0] ctl, input logic [1:0] fa,
                                input logic [1:0] fb, input logic err);
    exp_t e;
    e.ctl = ctl; e.fa = fa; e.fb = fb; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic check_output(input string tag);
    exp_t e;
    #2;
    e = exp_q.pop_front();
    if (inst_sel == 0) begin
      check_val({tag, ".ctl"}, 32'({stall_pc, stall_if_id, stall_id_ex,
                                   flush_if_id, flush_id_ex, flush_ex_mem}), 32'(e.ctl));
      check_val({tag, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
      check_val({tag, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
      check_val({tag, ".md_err"}, 32'(md_err), 32'(e.err));
      check_val({tag, ".stall_cnt"}, stall_cnt, PERF ? exp_stall : 32'd0);
      check_val({tag, ".flush_cnt"}, flush_cnt, PERF ? exp_flush : 32'd0);
    end else begin
      check_val({tag, ".ctl"}, 32'({t_stall_pc, t_stall_if_id, t_stall_id_ex,
                                   t_flush_if_id, t_flush_id_ex, t_flush_ex_mem}), 32'(e.ctl));
      check_val({tag, ".fwd_a"}, 32'(t_fwd_a), 32'(e.fa));
      check_val({tag, ".fwd_b"}, 32'(t_fwd_b), 32'(e.fb));
      check_val({tag, ".md_err"}, 32'(t_md_err), 32'(e.err));
    end
    if (rst_n) begin
      if (e.ctl[5]) exp_stall++;
      if (|e.ctl[2:0]) exp_flush++;
    end
  endtask

  task automatic step(input string tag, input logic [5:0] ctl, input logic [1:0] fa,
                      input logic [1:0] fb, input logic err);
    apply_stimulus(ctl, fa, fb, err);
    check_output(tag);
  endtask

  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    step("reset", C_NONE, 2'b00, 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    quiet();
    rst_n = 1'b0;
    do_reset();

    cyc(); step("idle", C_NONE, 2'b00, 2'b00, 1'b0);

    cyc(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    step("lu_rs1", C_LU, 2'b00, 2'b00, 1'b0);
    cyc(); step("lu_after", C_NONE, 2'b00, 2'b00, 1'b0);
    cyc(); ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    step("lu_x0", C_NONE, 2'b00, 2'b00, 1'b0);
    cyc(); ex_mem_read = 1; ex_rd = 12; id_rs2 = 12; id_use_rs2 = 1;
    step("lu_rs2", C_LU, 2'b00, 2'b00, 1'b0);
    cyc(); ex_mem_read = 1; ex_rd = 12; id_rs2 = 12; id_use_rs2 = 0;
    step("lu_unused", C_NONE, 2'b00, 2'b00, 1'b0);
    cyc(); ex_mem_read = 0; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    step("lu_noload", C_NONE, 2'b00, 2'b00, 1'b0);

    cyc(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; branch_taken_ex = 1;
    step("redir_lu", C_REDIR, 2'b00, 2'b00, 1'b0);

    cyc(); ex_rs1 = 7; mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1;
    step("fwd_mem", C_NONE, 2'b10, 2'b00, 1'b0);
    cyc(); ex_rs1 = 7; mem_rd = 7; wb_rd = 7; mem_reg_write = 0; wb_reg_write = 1;
    step("fwd_wb", C_NONE, 2'b01, 2'b00, 1'b0);
    cyc(); ex_rs1 = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1; wb_reg_write = 1;
    step("fwd_x0", C_NONE, 2'b00, 2'b00, 1'b0);
    cyc(); ex_rs1 = 3; ex_rs2 = 9; mem_rd = 3; wb_rd = 9; mem_reg_write = 1; wb_reg_write = 1;
    step("fwd_split", C_NONE, 2'b10, 2'b01, 1'b0);

    do_reset();
    cyc(); md_start = 1;
    step("md_start", C_MD, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 32; i++) begin
      cyc(); branch_taken_ex = (i == 5); ex_mem_read = (i == 9); ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
      step("md_wait", C_MD, 2'b00, 2'b00, 1'b0);
    end
    cyc(); md_done = 1;
    step("md_done", C_NONE, 2'b00, 2'b00, 1'b0);
    cyc(); step("md_idle", C_NONE, 2'b00, 2'b00, 1'b0);
    check_val("md_stall_cnt33", stall_cnt, PERF ? 32'd33 : 32'd0);
    check_val("md_flush_cnt33", flush_cnt, PERF ? 32'd33 : 32'd0);

    cyc(); md_start = 1; md_done = 1;
    step("md_same_cycle", C_NONE, 2'b00, 2'b00, 1'b0);
    cyc(); md_done = 1;
    step("md_done_idle", C_NONE, 2'b00, 2'b00, 1'b0);
    cyc(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    step("lu_after_md", C_LU, 2'b00, 2'b00, 1'b0);

    cyc(); md_start = 1;
    step("ar_start", C_MD, 2'b00, 2'b00, 1'b0);
    cyc(); step("ar_wait", C_MD, 2'b00, 2'b00, 1'b0);
    cyc(); #1; rst_n = 1'b0; exp_stall = 0; exp_flush = 0;
    step("async_rst", C_NONE, 2'b00, 2'b00, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    cyc(); step("ar_idle", C_NONE, 2'b00, 2'b00, 1'b0);

    inst_sel = 1;
    do_reset();
    cyc(); md_start = 1;
    step("to_start", C_MD, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cyc(); step("to_wait", C_MD, 2'b00, 2'b00, 1'b0);
    end
    cyc(); step("to_err", C_NONE, 2'b00, 2'b00, 1'b1);
    cyc(); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    step("to_idle_lu", C_LU, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(); step("to_sticky", C_NONE, 2'b00, 2'b00, 1'b1);
    end
    cyc(); #1; rst_n = 1'b0;
    step("to_rst", C_NONE, 2'b00, 2'b00, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    inst_sel = 0;
    do_reset();
    cyc(); step("final_idle", C_NONE, 2'b00, 2'b00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
